// File: rtl/nrs_pkg.sv
// Shared NRS constants and the product rounding helper.
// The TX mapper and this receiver both import this package, so the pilot magnitude cannot drift between them.
package nrs_pkg;

  // Sample format: signed Q5.11.
  localparam int DATA_W = 16;
  localparam int FRAC   = 11;

  // Pilot magnitude a = 0.7071 in Q5.11.
  localparam logic [15:0] NRS_PILOT_MAG = 16'h05A8;

  // Width of a (DATA_W+1)-bit sum multiplied by the scale constant.
  localparam int PROD_W = 2 * DATA_W + 1;

  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (FRAC - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = ~SAT_MAX;

  // Round half-up, drop the FRAC fraction bits, then clamp to the sample range.
  function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] rounded;
    logic signed [PROD_W-1:0] shifted;
    rounded = p + RND_HALF;
    shifted = rounded >>> FRAC;
    if (shifted > SAT_MAX) begin
      sat_round = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_round = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_round = shifted[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/nrs_cmul_sign.sv
// Two-stage LS estimate for one pilot: H = Y * conj(X) with X = a*(s_r + j*s_i).
// Stage 1 strips the pilot signs using add/sub only.
// Stage 2 applies the common magnitude a, then rounds and saturates.
// A one-bit tag rides along with each sample.
module nrs_cmul_sign
  import nrs_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic                     tag_i,
  input  logic signed [DATA_W-1:0] y_r_i,
  input  logic signed [DATA_W-1:0] y_i_i,
  input  logic                     c_r_i,
  input  logic                     c_i_i,
  output logic                     valid_o,
  output logic                     tag_o,
  output logic signed [DATA_W-1:0] h_r_o,
  output logic signed [DATA_W-1:0] h_i_o
);

  localparam int SUM_W = DATA_W + 1;
  localparam logic signed [PROD_W-1:0] SCALE_X = PROD_W'(NRS_PILOT_MAG);

  logic signed [SUM_W-1:0]  yr_x, yi_x;
  logic signed [SUM_W-1:0]  yr_sr, yi_sr, yr_si, yi_si;
  logic signed [SUM_W-1:0]  sum_r_d, sum_i_d;
  logic signed [SUM_W-1:0]  sum_r_q, sum_i_q;
  logic                     s1_valid_q, s1_tag_q;
  logic signed [PROD_W-1:0] prod_r, prod_i;
  logic signed [DATA_W-1:0] h_r_d, h_i_d;
  logic signed [DATA_W-1:0] h_r_q, h_i_q;
  logic                     h_valid_q, h_tag_q;

  // Sign-extend the inputs by one bit so that negating -2^(DATA_W-1) cannot wrap.
  assign yr_x = SUM_W'(y_r_i);
  assign yi_x = SUM_W'(y_i_i);

  // Stage-1 sums: sum_r = s_r*y_r + s_i*y_i and sum_i = s_r*y_i - s_i*y_r.
  always_comb begin
    yr_sr   = c_r_i ? -yr_x : yr_x;
    yi_sr   = c_r_i ? -yi_x : yi_x;
    yr_si   = c_i_i ? -yr_x : yr_x;
    yi_si   = c_i_i ? -yi_x : yi_x;
    sum_r_d = yr_sr + yi_si;
    sum_i_d = yi_sr - yr_si;
  end

  // Stage-1 register: the data only loads when an input sample is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= 1'b0;
      sum_r_q    <= '0;
      sum_i_q    <= '0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_tag_q <= tag_i;
        sum_r_q  <= sum_r_d;
        sum_i_q  <= sum_i_d;
      end
    end
  end

  // Stage-2 magnitude scaling followed by rounding and saturation.
  always_comb begin
    prod_r = PROD_W'(sum_r_q) * SCALE_X;
    prod_i = PROD_W'(sum_i_q) * SCALE_X;
    h_r_d  = sat_round(prod_r);
    h_i_d  = sat_round(prod_i);
  end

  // Stage-2 register: the estimate holds its value between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid_q <= 1'b0;
      h_tag_q   <= 1'b0;
      h_r_q     <= '0;
      h_i_q     <= '0;
    end else begin
      h_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        h_tag_q <= s1_tag_q;
        h_r_q   <= h_r_d;
        h_i_q   <= h_i_d;
      end
    end
  end

  assign valid_o = h_valid_q;
  assign tag_o   = h_tag_q;
  assign h_r_o   = h_r_q;
  assign h_i_o   = h_i_q;

endmodule

// File: rtl/nrs_ls_estimator_rx.sv
// NRS least-squares channel estimator, receive side.
// Produces a per-pilot estimate and an average over windows of 2^AVG_LOG2 pilots.
// A sym_start pulse restarts the averaging window.
module nrs_ls_estimator_rx
  import nrs_pkg::*;
#(
  parameter int AVG_LOG2 = 1
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nrs_valid,
  input  logic                     sym_start,
  input  logic signed [DATA_W-1:0] y_r,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic                     c_r,
  input  logic                     c_i,
  output logic                     h_valid,
  output logic signed [DATA_W-1:0] h_r,
  output logic signed [DATA_W-1:0] h_i,
  output logic                     h_avg_valid,
  output logic signed [DATA_W-1:0] h_avg_r,
  output logic signed [DATA_W-1:0] h_avg_i
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(1) << AVG_LOG2;

  logic                     h_sym;
  logic signed [ACC_W-1:0]  acc_r_q, acc_i_q, acc_r_d, acc_i_d;
  logic signed [ACC_W-1:0]  acc_r_sum, acc_i_sum;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_sum;
  logic                     win_done;
  logic signed [DATA_W-1:0] avg_r_d, avg_i_d;
  logic signed [DATA_W-1:0] h_avg_r_q, h_avg_i_q;
  logic                     h_avg_valid_q;

  nrs_cmul_sign u_cmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (nrs_valid),
    .tag_i   (sym_start),
    .y_r_i   (y_r),
    .y_i_i   (y_i),
    .c_r_i   (c_r),
    .c_i_i   (c_i),
    .valid_o (h_valid),
    .tag_o   (h_sym),
    .h_r_o   (h_r),
    .h_i_o   (h_i)
  );

  // Window bookkeeping. A delayed sym_start seeds a new window, and a completed window clears the state.
  always_comb begin
    acc_r_sum = h_sym ? ACC_W'(h_r) : acc_r_q + ACC_W'(h_r);
    acc_i_sum = h_sym ? ACC_W'(h_i) : acc_i_q + ACC_W'(h_i);
    cnt_sum   = h_sym ? CNT_W'(1) : cnt_q + CNT_W'(1);
    win_done  = h_valid && (cnt_sum == WIN_LEN);
    acc_r_d   = acc_r_q;
    acc_i_d   = acc_i_q;
    cnt_d     = cnt_q;
    if (h_valid) begin
      if (win_done) begin
        acc_r_d = '0;
        acc_i_d = '0;
        cnt_d   = '0;
      end else begin
        acc_r_d = acc_r_sum;
        acc_i_d = acc_i_sum;
        cnt_d   = cnt_sum;
      end
    end
  end

  generate
    if (AVG_LOG2 == 0) begin : g_no_avg
      // A window holds a single pilot, so the average is the estimate itself.
      assign avg_r_d = acc_r_sum;
      assign avg_i_d = acc_i_sum;
    end else begin : g_avg
      localparam logic signed [ACC_W-1:0] AVG_HALF = ACC_W'(1) << (AVG_LOG2 - 1);
      logic signed [ACC_W-1:0]  rnd_r, rnd_i;
      logic [2*AVG_LOG2-1:0]    rnd_unused;
      // Round half-up. Taking the top DATA_W bits is the arithmetic shift, and the result cannot overflow.
      assign rnd_r      = acc_r_sum + AVG_HALF;
      assign rnd_i      = acc_i_sum + AVG_HALF;
      assign avg_r_d    = rnd_r[ACC_W-1:AVG_LOG2];
      assign avg_i_d    = rnd_i[ACC_W-1:AVG_LOG2];
      assign rnd_unused = {rnd_r[AVG_LOG2-1:0], rnd_i[AVG_LOG2-1:0]};
    end
  endgenerate

  // Averager state: accumulators, pilot counter, and the registered average output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r_q       <= '0;
      acc_i_q       <= '0;
      cnt_q         <= '0;
      h_avg_valid_q <= 1'b0;
      h_avg_r_q     <= '0;
      h_avg_i_q     <= '0;
    end else begin
      acc_r_q       <= acc_r_d;
      acc_i_q       <= acc_i_d;
      cnt_q         <= cnt_d;
      h_avg_valid_q <= win_done;
      if (win_done) begin
        h_avg_r_q <= avg_r_d;
        h_avg_i_q <= avg_i_d;
      end
    end
  end

  assign h_avg_valid = h_avg_valid_q;
  assign h_avg_r     = h_avg_r_q;
  assign h_avg_i     = h_avg_i_q;

endmodule
